seg_scan_ctrl: RTL and testbench

Time-multiplexing scan controller for the board's 8-digit common-segment seven-segment display. It owns the shared segment bus SEGA..SEGG and grants it to one digit strobe SEGCOM1..SEGCOM8 per time slot. A dead-time blank separates slots to suppress ghosting. It holds eight 4-bit digit registers written by the counter datapath and decodes them to hex glyphs, with optional leading-zero suppression.

---
 rtl/seg_pkg.sv | 19 +
 rtl/seg_scan_ctrl_if.sv | 12 +
 rtl/seg7_decode.sv | 11 +
 rtl/seg_scan_ctrl.sv | 99 +++++++++
 tb/tb_seg_scan_ctrl.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: shared glyph table, scan state encoding and display polarity constants
package seg_pkg;

    typedef enum logic {BLANK = 1'b0, SHOW = 1'b1} state_t;

    localparam logic COM_ON  = 1'b0;
    localparam logic COM_OFF = 1'b1;
    localparam logic SEG_OFF = 1'b0;

    localparam logic [7:0] COM_ALL_OFF = {8{COM_OFF}};
    localparam logic [6:0] SEG_ALL_OFF = {7{SEG_OFF}};

    // {g,f,e,d,c,b,a} per hex value, entry 15 first
    localparam logic [15:0][6:0] GLYPH = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if: digit register write bus and display options into the scan controller
interface seg_scan_ctrl_if;

    logic       wr_en;
    logic [2:0] wr_addr;
    logic [3:0] wr_data;
    logic       lz_en;

    modport master (output wr_en, wr_addr, wr_data, lz_en);
    modport slave  (input  wr_en, wr_addr, wr_data, lz_en);

endinterface

// File: rtl/seg7_decode.sv
// seg7_decode: 4-bit hex value to active-high {g..a} segment pattern
module seg7_decode
    import seg_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    assign seg = GLYPH[digit];

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 8-digit multiplexed seven-segment scan with dead-time blanking and leading-zero suppression
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int DEAD     = 16
) (
    input  logic             clk,
    input  logic             reset,
    seg_scan_ctrl_if.slave   bus,
    output logic             SEGA,
    output logic             SEGB,
    output logic             SEGC,
    output logic             SEGD,
    output logic             SEGE,
    output logic             SEGF,
    output logic             SEGG,
    output logic             SEGCOM1,
    output logic             SEGCOM2,
    output logic             SEGCOM3,
    output logic             SEGCOM4,
    output logic             SEGCOM5,
    output logic             SEGCOM6,
    output logic             SEGCOM7,
    output logic             SEGCOM8,
    output logic             slot_tick
);

    state_t      state;
    logic [19:0] cnt;
    logic [2:0]  idx;
    logic [3:0]  digit_reg [8];
    logic [3:0]  shadow;
    logic        shadow_blank;
    logic [7:0]  com_q;
    logic [6:0]  seg_q;
    logic        tick_q;
    logic [6:0]  glyph;
    logic [7:0]  nz;
    logic        zero_up;
    logic        latch;
    logic        last;

    for (genvar i = 0; i < 8; i++) begin : g_nz
        assign nz[i] = |digit_reg[i];
    end

    // digit idx and everything above it are zero -> candidate for suppression
    assign zero_up = (nz >> idx) == 8'd0;
    assign latch   = state == BLANK && cnt == 20'(DEAD - 1);
    assign last    = state == SHOW && cnt == 20'(SCAN_DIV - 1);

    seg7_decode u_dec (
        .digit (shadow),
        .seg   (glyph)
    );

    // digit register file written by the counter datapath
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) digit_reg[i] <= 4'd0;
        end else if (bus.wr_en) begin
            digit_reg[bus.wr_addr] <= bus.wr_data;
        end
    end

    // scan FSM; outputs follow the state one cycle later so blanking brackets every strobe
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= BLANK;
            cnt          <= 20'd0;
            idx          <= 3'd0;
            shadow       <= 4'd0;
            shadow_blank <= 1'b0;
            com_q        <= COM_ALL_OFF;
            seg_q        <= SEG_ALL_OFF;
            tick_q       <= 1'b0;
        end else begin
            cnt    <= last ? 20'd0 : cnt + 20'd1;
            com_q  <= state == SHOW ? COM_ALL_OFF ^ (8'd1 << idx) : COM_ALL_OFF;
            seg_q  <= state == SHOW && !shadow_blank ? glyph : SEG_ALL_OFF;
            tick_q <= last;
            if (latch) begin
                shadow       <= digit_reg[idx];
                shadow_blank <= bus.lz_en && idx != 3'd0 && zero_up;
                state        <= SHOW;
            end
            if (last) begin
                idx   <= idx + 3'd1;
                state <= BLANK;
            end
        end
    end

    assign {SEGG, SEGF, SEGE, SEGD, SEGC, SEGB, SEGA} = seg_q;
    assign {SEGCOM8, SEGCOM7, SEGCOM6, SEGCOM5, SEGCOM4, SEGCOM3, SEGCOM2, SEGCOM1} = com_q;
    assign slot_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed checks of scan timing, glyphs, write latching, suppression and reset
module tb_seg_scan_ctrl;

    localparam int SD = 8;
    localparam int DT = 2;

    logic clk = 1'b0;
    logic reset;
    logic SEGA, SEGB, SEGC, SEGD, SEGE, SEGF, SEGG;
    logic SEGCOM1, SEGCOM2, SEGCOM3, SEGCOM4, SEGCOM5, SEGCOM6, SEGCOM7, SEGCOM8;
    logic slot_tick;
    logic [7:0] com;
    logic [6:0] seg;

    int checks = 0;
    int errors = 0;
    int n = 0;
    logic [3:0] dig [8];
    logic [3:0] lat = 4'd0;
    logic lat_blank = 1'b0;
    logic [7:0] prev_com = 8'hFF;
    logic [6:0] prev_seg = 7'h00;
    logic [6:0] gl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    seg_scan_ctrl_if bus ();

    seg_scan_ctrl #(.SCAN_DIV(SD), .DEAD(DT)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .SEGA(SEGA), .SEGB(SEGB), .SEGC(SEGC), .SEGD(SEGD), .SEGE(SEGE), .SEGF(SEGF), .SEGG(SEGG),
        .SEGCOM1(SEGCOM1), .SEGCOM2(SEGCOM2), .SEGCOM3(SEGCOM3), .SEGCOM4(SEGCOM4),
        .SEGCOM5(SEGCOM5), .SEGCOM6(SEGCOM6), .SEGCOM7(SEGCOM7), .SEGCOM8(SEGCOM8),
        .slot_tick(slot_tick)
    );

    always #5 clk = ~clk;

    assign com = {SEGCOM8, SEGCOM7, SEGCOM6, SEGCOM5, SEGCOM4, SEGCOM3, SEGCOM2, SEGCOM1};
    assign seg = {SEGG, SEGF, SEGE, SEGD, SEGC, SEGB, SEGA};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic zero_from(input int d);
        for (int i = d; i < 8; i++) if (dig[i] != 4'd0) return 1'b0;
        return 1'b1;
    endfunction

    // one clock: model the latch and write at the edge, then compare all outputs
    task automatic step();
        int e, d;
        logic low;
        logic [7:0] ec;
        logic [6:0] es;
        e = reset ? n + 1 : 0;
        if (e % SD == DT) begin
            d = (e / SD) % 8;
            lat = dig[d];
            lat_blank = bus.lz_en && d != 0 && zero_from(d);
        end
        if (!reset) for (int i = 0; i < 8; i++) dig[i] = 4'd0;
        else if (bus.wr_en) dig[bus.wr_addr] = bus.wr_data;
        @(posedge clk);
        n = e;
        @(negedge clk);
        low = n >= DT + 1 && (n - DT - 1) % SD < SD - DT;
        d = low ? ((n - DT - 1) / SD) % 8 : 0;
        ec = low ? ~(8'd1 << d) : 8'hFF;
        es = low && !lat_blank ? gl[lat] : 7'h00;
        check("com", com, ec);
        check("seg", seg, es);
        check("tick", slot_tick, n >= SD && n % SD == 0);
    endtask

    task automatic wr(input int a, input int d);
        bus.wr_en = 1'b1;
        bus.wr_addr = 3'(a);
        bus.wr_data = 4'(d);
        step();
        bus.wr_en = 1'b0;
    endtask

    task automatic run_to(input int k);
        do step(); while (n % (8 * SD) != k);
    endtask

    task automatic frame();
        run_to(0);
        repeat (8 * SD) step();
    endtask

    // never two strobes at once, and no segment change while a strobe is held
    always @(negedge clk) begin
        check("one_com", $countones(~com) <= 1, 1'b1);
        if (com != 8'hFF && com == prev_com) check("seg_stable", seg, prev_seg);
        prev_com = com;
        prev_seg = seg;
    end

    initial begin
        for (int i = 0; i < 8; i++) dig[i] = 4'd0;
        reset = 1'b0;
        bus.wr_en = 1'b0;
        bus.wr_addr = 3'd0;
        bus.wr_data = 4'd0;
        bus.lz_en = 1'b0;
        repeat (3) step();
        check("rst_com", com, 8'hFF);
        check("rst_seg", seg, 7'h00);
        check("rst_tick", slot_tick, 1'b0);
        reset = 1'b1;
        repeat (3) step();
        check("first_strobe", com, 8'hFE);
        check("first_glyph", seg, 7'h3F);
        repeat (69) step();
        for (int i = 0; i < 8; i++) wr(i, i);
        frame();
        for (int i = 0; i < 8; i++) wr(i, 8 + i);
        frame();
        wr(3, 3);
        run_to(0);
        run_to(28);
        check("mid_hold", seg, 7'h4F);
        wr(3, 8);
        check("mid_keep", seg, 7'h4F);
        run_to(0);
        run_to(28);
        check("mid_new", seg, 7'h7F);
        bus.lz_en = 1'b1;
        for (int i = 0; i < 8; i++) wr(i, i == 5 ? 1 : 0);
        frame();
        run_to(51);
        check("lz_d6_seg", seg, 7'h00);
        check("lz_d6_com", com, 8'hBF);
        run_to(43);
        check("lz_d5_seg", seg, 7'h06);
        run_to(19);
        check("lz_d2_seg", seg, 7'h3F);
        wr(5, 0);
        frame();
        run_to(3);
        check("lz_all_d0", seg, 7'h3F);
        check("lz_all_d0_com", com, 8'hFE);
        run_to(11);
        check("lz_all_d1", seg, 7'h00);
        check("lz_all_d1_com", com, 8'hFD);
        bus.lz_en = 1'b0;
        wr(0, 7);
        wr(2, 5);
        run_to(45);
        check("pre_rst_com", com, 8'hDF);
        reset = 1'b0;
        step();
        check("mid_rst_com", com, 8'hFF);
        check("mid_rst_seg", seg, 7'h00);
        for (int i = 0; i < 8; i++) check("mid_rst_reg", dut.digit_reg[i], 4'd0);
        repeat (2) step();
        reset = 1'b1;
        repeat (3) step();
        check("restart_com", com, 8'hFE);
        check("restart_seg", seg, 7'h3F);
        repeat (10) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
